// File: rtl/kcs_tx.sv
// -----------------------------------------------------------------------------
// kcs_tx : Kansas City Standard (CUTS, 300 baud) cassette encoder
//
// Takes bytes over a valid/ready handshake and sends each one as a frame:
// 1 start bit, 8 data bits (LSB first) and STOP_BITS stop bits. Each bit slot
// is 16 ticks long, and one tick is TONE_DIV clocks. A mark (1) toggles
// cas_out on every tick, which gives 2400 Hz. A space (0) toggles cas_out on
// every odd tick index, which gives 1200 Hz.
//
// Parameters
//   TONE_DIV  : clocks per half-period of the 2400 Hz tone (2..65535)
//   STOP_BITS : stop bits per frame (1..3)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   byte to send, sampled on the accept cycle only
//   tx_valid  in   producer has a byte
//   tx_ready  out  holding register is empty
//   tx_busy   out  a frame is on the wire (START, DATA or STOP)
//   cas_out   out  square-wave audio output
//
// Build option
//   KCS_TX_LEADER_EN : when defined, the tick and slot counters free-run in
//                      IDLE and cas_out carries a continuous mark tone
//                      (leader), so frames start on the slot grid. When
//                      undefined, IDLE is silent with the counters at 0, and
//                      a held byte starts its frame on the next clock.
// -----------------------------------------------------------------------------
module kcs_tx #(
   parameter int unsigned TONE_DIV  = 833,
   parameter int unsigned STOP_BITS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       cas_out
);

   localparam int unsigned TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TONE_DIV - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    slot_cnt_q, slot_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          cas_q, cas_d;
   logic          busy_q, busy_d;
   logic          ready_q, ready_d;

   logic          tick_s;
   logic          slot_end_s;
   logic          accept_s;
   logic          idle_load_s;
   logic          load_s;
   logic          bit_s;
   logic          toggle_s;

   assign tick_s     = (tick_cnt_q == TICK_MAX);
   assign slot_end_s = tick_s && (slot_cnt_q == 4'd15);
   assign accept_s   = tx_valid && ready_q;

`ifdef KCS_TX_LEADER_EN
   // With the leader running, a held byte waits for the next slot boundary.
   assign idle_load_s = slot_end_s && hold_full_q;
`else
   // Silent IDLE has no slot grid, so a held byte starts on the next clock.
   assign idle_load_s = hold_full_q;
`endif

   // Frame sequencing: state, bit index and shift register next state.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      load_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (idle_load_s) begin
               state_d   = ST_START;
               bit_idx_d = 3'd0;
               load_s    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (slot_end_s) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (slot_end_s) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d   = ST_STOP;
                  bit_idx_d = 3'd0;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (slot_end_s) begin
               if (bit_idx_q == STOP_LAST) begin
                  bit_idx_d = 3'd0;
                  // Back-to-back frames: the next start slot follows at once.
                  if (hold_full_q) begin
                     state_d = ST_START;
                     load_s  = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_idx_d = 3'd0;
         end
      endcase
      if (load_s) begin
         shift_d = hold_q;
      end else begin
         shift_d = shift_d;
      end
   end

   // Holding register: a transfer empties it and an accept refills it. If
   // both happen in one cycle, the transfer takes the old byte and the new
   // byte stays held.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (load_s) begin
         hold_full_d = 1'b0;
      end else begin
         hold_full_d = hold_full_q;
      end
      if (accept_s) begin
         hold_full_d = 1'b1;
         hold_d      = tx_data;
      end else begin
         hold_d = hold_q;
      end
      ready_d = !hold_full_d;
      busy_d  = (state_d != ST_IDLE);
   end

   // Tick and slot counters; they are held at 0 in silent IDLE.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      slot_cnt_d = slot_cnt_q;
`ifdef KCS_TX_LEADER_EN
      if (tick_s) begin
`else
      if (state_q == ST_IDLE) begin
         tick_cnt_d = '0;
         slot_cnt_d = 4'd0;
      end else if (tick_s) begin
`endif
         tick_cnt_d = '0;
         slot_cnt_d = slot_cnt_q + 4'd1;
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
         slot_cnt_d = slot_cnt_q;
      end
   end

   // Tone: the bit on the wire selects the toggle rate, and the phase carries
   // across slot boundaries.
   always_comb begin
      bit_s = 1'b1;
      case (state_q)
         ST_IDLE:  bit_s = 1'b1;
         ST_START: bit_s = 1'b0;
         ST_DATA:  bit_s = shift_q[0];
         ST_STOP:  bit_s = 1'b1;
         default:  bit_s = 1'b1;
      endcase
      toggle_s = tick_s && (bit_s || slot_cnt_q[0]);
`ifdef KCS_TX_LEADER_EN
      cas_d = cas_q ^ toggle_s;
`else
      if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
         cas_d = 1'b0;
      end else begin
         cas_d = cas_q ^ toggle_s;
      end
`endif
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tick_cnt_q  <= '0;
         slot_cnt_q  <= 4'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         cas_q       <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         slot_cnt_q  <= slot_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cas_q       <= cas_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;
   assign cas_out  = cas_q;

endmodule

// File: tb/tb_kcs_tx.sv
// -----------------------------------------------------------------------------
// tb_kcs_tx : randomized self-checking bench for kcs_tx (silent-IDLE build).
// There are two instances: A (TONE_DIV=4, STOP_BITS=2) and B (TONE_DIV=2,
// STOP_BITS=1). A reference model works out the expected waveform from each
// frame's bit list and its time into the frame.
// -----------------------------------------------------------------------------
module tb_kcs_tx;

   localparam int TD_A = 4;
   localparam int SB_A = 2;
   localparam int TD_B = 2;
   localparam int SB_B = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       ready_a, ready_b, busy_a, busy_b, cas_a, cas_b;

   kcs_tx #(.TONE_DIV(TD_A), .STOP_BITS(SB_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a),
      .tx_ready(ready_a), .tx_busy(busy_a), .cas_out(cas_a));

   kcs_tx #(.TONE_DIV(TD_B), .STOP_BITS(SB_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b),
      .tx_ready(ready_b), .tx_busy(busy_b), .cas_out(cas_b));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, one entry per instance.
   int         td[2];
   int         sb[2];
   bit         m_busy[2];
   int         m_t[2];
   logic [7:0] m_byte[2];
   bit         m_hold_full[2];
   logic [7:0] m_hold[2];
   int         run[2];
   int         last_run[2];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int frame_len(int i);
      return (9 + sb[i]) * 16 * td[i];
   endfunction

   // Expected cas_out: every slot contains an even number of toggles, so
   // the level depends only on the ticks completed in the current slot.
   function automatic logic exp_cas(int i);
      int slot_len, slot, nt;
      logic b;
      if (!m_busy[i]) return 1'b0;
      slot_len = 16 * td[i];
      slot = m_t[i] / slot_len;
      nt = (m_t[i] % slot_len) / td[i];
      if (slot == 0) b = 1'b0;
      else if (slot <= 8) b = m_byte[i][slot-1];
      else b = 1'b1;
      return b ? logic'(nt % 2) : logic'((nt / 2) % 2);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0;
         m_t[i] = 0;
         m_hold_full[i] = 1'b0;
      end
   endtask

   task automatic model_edge(int i, bit acc, logic [7:0] din);
      bit xfer, fin;
      xfer = 1'b0;
      fin = 1'b0;
      if (!m_busy[i] && m_hold_full[i]) xfer = 1'b1;
      else if (m_busy[i] && m_t[i] == frame_len(i) - 1) begin
         fin = 1'b1;
         if (m_hold_full[i]) xfer = 1'b1;
      end
      if (xfer) begin
         m_byte[i] = m_hold[i];
         m_busy[i] = 1'b1;
         m_t[i] = 0;
      end else if (fin) begin
         m_busy[i] = 1'b0;
         m_t[i] = 0;
      end else if (m_busy[i]) begin
         m_t[i]++;
      end
      if (xfer) m_hold_full[i] = acc;
      else m_hold_full[i] = m_hold_full[i] | acc;
      if (acc) m_hold[i] = din;
   endtask

   task automatic check_outputs();
      check_val("a_cas", {31'd0, cas_a}, {31'd0, exp_cas(0)});
      check_val("a_busy", {31'd0, busy_a}, {31'd0, m_busy[0]});
      check_val("a_ready", {31'd0, ready_a}, {31'd0, !m_hold_full[0]});
      check_val("b_cas", {31'd0, cas_b}, {31'd0, exp_cas(1)});
      check_val("b_busy", {31'd0, busy_b}, {31'd0, m_busy[1]});
      check_val("b_ready", {31'd0, ready_b}, {31'd0, !m_hold_full[1]});
   endtask

   // One clock: advance the model on the edge, then compare 1 time unit later.
   task automatic step();
      bit acc0, acc1;
      logic [7:0] d0, d1;
      acc0 = valid_a && !m_hold_full[0];
      acc1 = valid_b && !m_hold_full[1];
      d0 = data_a;
      d1 = data_b;
      @(posedge clk);
      if (!rst_n) model_clear();
      else begin
         model_edge(0, acc0, d0);
         model_edge(1, acc1, d1);
      end
      #1;
      check_outputs();
      if (busy_a) run[0]++;
      else if (run[0] > 0) begin last_run[0] = run[0]; run[0] = 0; end
      if (busy_b) run[1]++;
      else if (run[1] > 0) begin last_run[1] = run[1]; run[1] = 0; end
   endtask

   task automatic drive(int i, logic v, logic [7:0] d);
      if (i == 0) begin valid_a = v; data_a = d; end
      else begin valid_b = v; data_b = d; end
   endtask

   // Present a byte until the model sees it accepted.
   task automatic send(int i, logic [7:0] b, bit keep);
      bit done, will;
      int n;
      done = 1'b0;
      n = 0;
      while (!done && n < 3000) begin
         drive(i, 1'b1, b);
         will = !m_hold_full[i];
         step();
         n++;
         if (will) done = 1'b1;
      end
      if (!keep) drive(i, 1'b0, 8'h00);
      if (!done) check_val("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(int i);
      int n;
      n = 0;
      while ((m_busy[i] || m_hold_full[i]) && n < 8000) begin
         step();
         n++;
      end
      if (m_busy[i] || m_hold_full[i]) check_val("idle_timeout", 32'd0, 32'd1);
      step();
   endtask

   initial begin
      td[0] = TD_A; sb[0] = SB_A;
      td[1] = TD_B; sb[1] = SB_B;
      run[0] = 0; run[1] = 0;
      last_run[0] = 0; last_run[1] = 0;
      m_byte[0] = 8'h00; m_byte[1] = 8'h00;
      m_hold[0] = 8'h00; m_hold[1] = 8'h00;
      model_clear();
      rst_n = 1'b0;
      valid_a = 1'b0; valid_b = 1'b0; data_a = 8'h00; data_b = 8'h00;

      // Reset held with random inputs.
      for (int k = 0; k < 6; k++) begin
         valid_a = 1'($urandom); data_a = 8'($urandom);
         valid_b = 1'($urandom); data_b = 8'($urandom);
         step();
      end
      valid_a = 1'b0; valid_b = 1'b0;
      rst_n = 1'b1;
      repeat (5) step();

      // Single byte 0x55 on A.
      send(0, 8'h55, 1'b0);
      wait_idle(0);
      check_val("a_len_55", 32'(last_run[0]), 32'(frame_len(0)));

      // Back-to-back 0x00 then 0xFF with no gap between the two frames.
      send(0, 8'h00, 1'b0);
      send(0, 8'hFF, 1'b0);
      check_val("a_busy_2nd_accept", {31'd0, busy_a}, 32'd1);
      wait_idle(0);
      check_val("a_len_b2b", 32'(last_run[0]), 32'(2 * frame_len(0)));

      // Four queued bytes with tx_valid held high.
      send(0, 8'h12, 1'b1);
      send(0, 8'h34, 1'b1);
      send(0, 8'h56, 1'b1);
      send(0, 8'h78, 1'b0);
      wait_idle(0);
      check_val("a_len_q4", 32'(last_run[0]), 32'(4 * frame_len(0)));

      // Asynchronous reset during data bit 3 of 0xA5.
      send(0, 8'hA5, 1'b0);
      begin
         int n;
         n = 0;
         while (!(m_busy[0] && m_t[0] >= 4 * 16 * TD_A + 9) && n < 2000) begin
            step();
            n++;
         end
         if (n >= 2000) check_val("a_reach_bit3", 32'd0, 32'd1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_val("a_async_cas", {31'd0, cas_a}, 32'd0);
      check_val("a_async_busy", {31'd0, busy_a}, 32'd0);
      check_val("a_async_ready", {31'd0, ready_a}, 32'd1);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();
      send(0, 8'h3C, 1'b0);
      wait_idle(0);
      check_val("a_len_3c", 32'(last_run[0]), 32'(frame_len(0)));

      // B: one stop bit, short tone, random bytes with idle gaps.
      for (int k = 0; k < 3; k++) begin
         send(1, 8'($urandom), 1'b0);
         wait_idle(1);
         check_val("b_len", 32'(last_run[1]), 32'(frame_len(1)));
         repeat ($urandom_range(1, 20)) step();
      end

      // Random traffic on both instances.
      for (int k = 0; k < 4000; k++) begin
         valid_a = ($urandom_range(0, 3) == 0);
         data_a = 8'($urandom);
         valid_b = ($urandom_range(0, 2) == 0);
         data_b = 8'($urandom);
         step();
      end
      valid_a = 1'b0; valid_b = 1'b0;
      wait_idle(0);
      wait_idle(1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
